// File: rtl/cache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_bridge_pkg
// Description : Shared request-type codes, AXI constants, FSM state types and
//               a helper that maps a cache request type onto an AXI size.
// Revision    : 1.0  initial release
// ============================================================================
package cache_axi_bridge_pkg;

    // Cache request type codes
    localparam logic [2:0] CACHE_BYTE = 3'b000;
    localparam logic [2:0] CACHE_HALF = 3'b001;
    localparam logic [2:0] CACHE_WORD = 3'b010;
    localparam logic [2:0] CACHE_LINE = 3'b100;

    // AXI constants
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Line transfers always move full words; narrow accesses carry their
    // size in the low two bits of the type code.
    function automatic logic [2:0] axi_size_of(input logic [2:0] req_type);
        return (req_type == CACHE_LINE) ? SIZE_WORD : {1'b0, req_type[1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge_wr.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_ctrl
// Description : Write side of the cache/AXI bridge. Latches one write request
//               (address, type, strobe, full line data), issues AW and the W
//               beats independently, then waits for the B response.
// Ports       : aclk/aresetn      clock, async active-low reset
//               wr_*              cache write request / wr_rdy accept
//               aw*, w*, b*       AXI write address, data, response channels
//               wr_busy           write FSM not idle
//               wr_line           latched line address (addr[31:5])
// Revision    : 1.0  initial release
// ============================================================================
module axi_wr_ctrl
    import cache_axi_bridge_pkg::*;
#(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     wr_req,
    input  logic [2:0]               wr_type,
    input  logic [31:0]              wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                     wr_rdy,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready,
    output logic                     wr_busy,
    output logic [26:0]              wr_line
);

    localparam int         CNT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    wr_state_e                 state_q,   state_d;
    logic [31:0]               addr_q,    addr_d;
    logic [2:0]                type_q,    type_d;
    logic [3:0]                strb_q,    strb_d;
    logic [32*LINE_WORDS-1:0]  data_q,    data_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q,  w_done_d;

    logic is_line;
    logic aw_hs;
    logic w_hs;

    assign is_line = (type_q == CACHE_LINE);

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = is_line ? LINE_LEN : 8'd0;
    assign awsize  = axi_size_of(type_q);
    assign awburst = BURST_INCR;

    // AW and W are tracked separately so either may finish first.
    assign awvalid = (state_q == W_XFER) && !aw_done_q;
    assign wvalid  = (state_q == W_XFER) && !w_done_q;
    assign wdata   = data_q[{cnt_q, 5'd0} +: 32];
    assign wstrb   = is_line ? 4'hF : strb_q;
    assign wlast   = (8'(cnt_q) == awlen);

    assign bready  = (state_q == W_RESP);
    assign wr_rdy  = (state_q == W_IDLE);
    assign wr_busy = (state_q != W_IDLE);
    assign wr_line = addr_q[31:5];

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        type_d    = type_q;
        strb_d    = strb_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            W_IDLE: begin
                if (wr_req) begin
                    addr_d    = wr_addr;
                    type_d    = wr_type;
                    strb_d    = wr_wstrb;
                    data_d    = wr_data;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = W_XFER;
                end
            end
            W_XFER: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (wlast) begin
                        w_done_d = 1'b1;
                    end
                end
                // Leave once both channels are finished, counting a handshake
                // that completes in this very cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast))) begin
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            type_q    <= '0;
            strb_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            strb_q    <= strb_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_bridge
// Description : Memory-side responder for the merged cache request port.
//               Converts rd_req/wr_req into AXI read and write bursts, passes
//               read beats straight back as ret_*, and blocks reads that hit
//               the line of an in-flight or incoming write.
// Ports       : aclk/aresetn      clock, async active-low reset
//               rd_* / ret_*      cache read request and return beats
//               wr_*              cache write request
//               ar*, r*           AXI read address / data channels
//               aw*, w*, b*       AXI write address / data / response channels
// Revision    : 1.0  initial release
// ============================================================================
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     rd_req,
    input  logic [2:0]               rd_type,
    input  logic [31:0]              rd_addr,
    output logic                     rd_rdy,
    output logic                     ret_valid,
    output logic                     ret_last,
    output logic [31:0]              ret_data,
    input  logic                     wr_req,
    input  logic [2:0]               wr_type,
    input  logic [31:0]              wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                     wr_rdy,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rd_addr_q,  rd_addr_d;
    logic [2:0]  rd_type_q,  rd_type_d;

    logic        wr_busy;
    logic [26:0] wr_line;
    logic        haz_pending;
    logic        haz_incoming;
    logic        rd_hazard;

    // Read-after-write protection at line granularity: a read may not pass a
    // write to the same line, whether that write is already latched or is
    // being offered in this same cycle.
    assign haz_pending  = wr_busy && (rd_addr[31:5] == wr_line);
    assign haz_incoming = !wr_busy && wr_req && (rd_addr[31:5] == wr_addr[31:5]);
    assign rd_hazard    = haz_pending || haz_incoming;

    assign rd_rdy    = (rd_state_q == R_IDLE) && !rd_hazard;

    assign arid      = AXI_ID;
    assign araddr    = rd_addr_q;
    assign arlen     = (rd_type_q == CACHE_LINE) ? LINE_LEN : 8'd0;
    assign arsize    = axi_size_of(rd_type_q);
    assign arburst   = BURST_INCR;
    assign arvalid   = (rd_state_q == R_AR);

    // Read data is returned with zero latency straight from the R channel.
    assign rready    = (rd_state_q == R_DATA);
    assign ret_valid = rready && rvalid;
    assign ret_last  = rready && rlast;
    assign ret_data  = rdata;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_type_d  = rd_type_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_req && !rd_hazard) begin
                    rd_addr_d  = rd_addr;
                    rd_type_d  = rd_type;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                if (arready) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rlast) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_type_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_type_q  <= rd_type_d;
        end
    end

    axi_wr_ctrl #(
        .LINE_WORDS (LINE_WORDS),
        .AXI_ID     (AXI_ID)
    ) u_wr_ctrl (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_req   (wr_req),
        .wr_type  (wr_type),
        .wr_addr  (wr_addr),
        .wr_wstrb (wr_wstrb),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready),
        .wr_busy  (wr_busy),
        .wr_line  (wr_line)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_bridge
// Description : Self-checking bench for cache_axi_bridge. Table-driven hazard
//               probes and read transactions (scoreboard of return beats),
//               directed write bursts, and hand-written multi-cycle sequences
//               for read/write hazards, same-cycle requests and mid-burst reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cache_axi_bridge;
    import cache_axi_bridge_pkg::*;

    localparam int LW = 8;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            rd_req;
    logic [2:0]      rd_type;
    logic [31:0]     rd_addr;
    logic            rd_rdy;
    logic            ret_valid;
    logic            ret_last;
    logic [31:0]     ret_data;
    logic            wr_req;
    logic [2:0]      wr_type;
    logic [31:0]     wr_addr;
    logic [3:0]      wr_wstrb;
    logic [32*LW-1:0] wr_data;
    logic            wr_rdy;
    logic [3:0]      arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [3:0]      awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic            bvalid;
    logic            bready;

    always #5 aclk = ~aclk;

    cache_axi_bridge #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t sb_q[$];

    typedef struct {
        logic [31:0] rd_addr;
        logic        wr_req;
        logic [31:0] wr_addr;
        logic        exp_rd_rdy;
        logic        exp_wr_rdy;
    } hz_vec_t;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        int          ar_delay;
        int          gap;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
        logic [31:0] seed;
    } rd_vec_t;

    hz_vec_t hz_tab[6];
    rd_vec_t rd_tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_read(input rd_vec_t v);
        int    n;
        int    k;
        int    seen;
        int    lasts;
        logic  acc;
        beat_t eb;
        n = (v.typ == CACHE_LINE) ? LW : 1;
        cyc();
        rd_req = 1'b1; rd_type = v.typ; rd_addr = v.addr;
        k = 0; acc = 1'b0;
        while (!acc && k < 20) begin
            #1;
            acc = rd_rdy;
            cyc();
            k++;
        end
        chk("rd_accept", acc, 1);
        rd_req = 1'b0;
        for (int j = 0; j <= v.ar_delay; j++) begin
            arready = (j == v.ar_delay);
            #1;
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, v.addr);
            chk("arlen", arlen, v.exp_len);
            chk("arsize", arsize, v.exp_size);
            chk("arburst", arburst, BURST_INCR);
            chk("arid", arid, 0);
            chk("rready_in_ar", rready, 0);
            cyc();
        end
        arready = 1'b0;
        seen = 0; lasts = 0;
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < v.gap; g++) begin
                rvalid = 1'b0; rlast = 1'b0;
                #1;
                chk("ret_valid_gap", ret_valid, 0);
                chk("rready", rready, 1);
                cyc();
            end
            rvalid = 1'b1; rdata = v.seed + b; rlast = (b == n - 1);
            eb.data = v.seed + b;
            eb.last = (b == n - 1);
            sb_q.push_back(eb);
            #1;
            if (ret_valid) begin
                seen++;
                if (ret_last) lasts++;
                if (sb_q.size() > 0) begin
                    eb = sb_q.pop_front();
                    chk("ret_data", ret_data, eb.data);
                    chk("ret_last", ret_last, eb.last);
                end
            end else begin
                chk("ret_valid", ret_valid, 1);
            end
            chk("rd_rdy_busy", rd_rdy, 0);
            cyc();
        end
        rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        #1;
        chk("ret_count", seen, n);
        chk("ret_last_count", lasts, 1);
        chk("rd_rdy_after", rd_rdy, 1);
        chk("arvalid_after", arvalid, 0);
        sb_q.delete();
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] strb,
                            input logic [32*LW-1:0] d, input int aw_delay, input bit wgap,
                            input int resp_delay, input logic [2:0] exp_size,
                            input logic [3:0] exp_strb);
        int         n;
        int         beat;
        int         k;
        int         beats_at_aw;
        bit         aw_done;
        logic [7:0] exp_len;
        n       = (t == CACHE_LINE) ? LW : 1;
        exp_len = (t == CACHE_LINE) ? 8'd7 : 8'd0;
        cyc();
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = strb; wr_data = d;
        #1;
        chk("wr_rdy_idle", wr_rdy, 1);
        cyc();
        wr_req = 1'b0; wr_data = '0;
        aw_done = 1'b0; beat = 0; k = 0; beats_at_aw = -1;
        while (!(aw_done && beat == n) && k < 40) begin
            awready = (k >= aw_delay);
            wready  = wgap ? (k % 2 == 1) : 1'b1;
            #1;
            chk("bready_xfer", bready, 0);
            chk("wr_rdy_xfer", wr_rdy, 0);
            chk("awvalid", awvalid, !aw_done);
            if (!aw_done) begin
                chk("awaddr", awaddr, a);
                chk("awlen", awlen, exp_len);
                chk("awsize", awsize, exp_size);
                chk("awburst", awburst, BURST_INCR);
            end
            chk("wvalid", wvalid, beat < n);
            if (beat < n) begin
                chk("wdata", wdata, d[beat*32 +: 32]);
                chk("wstrb", wstrb, exp_strb);
                chk("wlast", wlast, beat == n - 1);
            end
            if (!aw_done && awready) begin
                aw_done = 1'b1;
                beats_at_aw = beat;
            end
            if (beat < n && wready) beat++;
            cyc();
            k++;
        end
        chk("wr_xfer_timeout", k < 40, 1);
        if (!wgap) chk("w_before_aw", beats_at_aw, (aw_delay < n) ? aw_delay : n);
        awready = 1'b0; wready = 1'b0;
        for (int r = 0; r < resp_delay; r++) begin
            #1;
            chk("bready_resp", bready, 1);
            chk("wr_rdy_resp", wr_rdy, 0);
            cyc();
        end
        bvalid = 1'b1;
        #1;
        chk("bready_b", bready, 1);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("wr_rdy_after_b", wr_rdy, 1);
        chk("bready_after_b", bready, 0);
    endtask

    task automatic drain_write();
        int k;
        k = 0;
        awready = 1'b1; wready = 1'b1;
        while (!bready && k < 20) begin
            cyc();
            k++;
        end
        chk("drain_w_timeout", k < 20, 1);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
    endtask

    task automatic drain_read();
        int k;
        k = 0;
        arready = 1'b1;
        while (!rready && k < 20) begin
            cyc();
            k++;
        end
        chk("drain_r_timeout", k < 20, 1);
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0;
        cyc();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32*LW-1:0] line_d;

        aresetn = 1'b0;
        rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        hz_tab[0] = '{32'h0000_1000, 1'b0, 32'h0000_1000, 1'b1, 1'b1};
        hz_tab[1] = '{32'h0000_1000, 1'b1, 32'h0000_1004, 1'b0, 1'b1};
        hz_tab[2] = '{32'h0000_101F, 1'b1, 32'h0000_1000, 1'b0, 1'b1};
        hz_tab[3] = '{32'h0000_1020, 1'b1, 32'h0000_101C, 1'b1, 1'b1};
        hz_tab[4] = '{32'hFFFF_FFE0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};
        hz_tab[5] = '{32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b1};

        rd_tab[0] = '{CACHE_WORD, 32'h0000_1004, 0, 0, 8'd0, 3'd2, 32'hDEAD_BEEF};
        rd_tab[1] = '{CACHE_LINE, 32'h0000_2000, 0, 1, 8'd7, 3'd2, 32'h2000_0000};
        rd_tab[2] = '{CACHE_BYTE, 32'h0000_1003, 3, 0, 8'd0, 3'd0, 32'h0000_00A5};
        rd_tab[3] = '{CACHE_HALF, 32'h0000_1002, 1, 2, 8'd0, 3'd1, 32'h0000_BEEF};
        rd_tab[4] = '{CACHE_LINE, 32'h0000_2020, 2, 0, 8'd7, 3'd2, 32'hC0DE_0000};

        // Reset state
        repeat (2) cyc();
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_ret_valid", ret_valid, 0);
        aresetn = 1'b1;
        #1;
        chk("rst_rd_rdy", rd_rdy, 1);
        chk("rst_wr_rdy", wr_rdy, 1);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_ret_last", ret_last, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);

        // Hazard probes with both FSMs idle; wr_req drops before the edge
        for (int i = 0; i < 6; i++) begin
            cyc();
            rd_addr = hz_tab[i].rd_addr;
            wr_req  = hz_tab[i].wr_req;
            wr_addr = hz_tab[i].wr_addr;
            wr_type = CACHE_WORD;
            #1;
            chk("hz_rd_rdy", rd_rdy, hz_tab[i].exp_rd_rdy);
            chk("hz_wr_rdy", wr_rdy, hz_tab[i].exp_wr_rdy);
            wr_req = 1'b0;
        end

        // Read transactions
        for (int i = 0; i < 5; i++) begin
            do_read(rd_tab[i]);
        end

        // Line write, AW held off until all W beats are done
        for (int i = 0; i < LW; i++) line_d[i*32 +: 32] = 32'h10 + i;
        do_write(CACHE_LINE, 32'h0000_3000, 4'h0, line_d, 9, 1'b0, 2, 3'd2, 4'hF);
        line_d = '0; line_d[31:0] = 32'h1234_5678;
        do_write(CACHE_WORD, 32'h0000_3104, 4'hF, line_d, 0, 1'b1, 1, 3'd2, 4'hF);
        line_d[31:0] = 32'h9ABC_DEF0;
        do_write(CACHE_HALF, 32'h0000_3202, 4'b1100, line_d, 2, 1'b0, 0, 3'd1, 4'hC);

        // Byte write pending blocks same-line read; other-line read proceeds
        cyc();
        wr_req = 1'b1; wr_type = CACHE_BYTE; wr_addr = 32'h0000_3003; wr_wstrb = 4'b1000;
        wr_data = '0; wr_data[31:0] = 32'hAABB_CCDD;
        rd_addr = 32'h0000_3000; rd_type = CACHE_WORD; rd_req = 1'b0;
        #1;
        chk("haz_incoming", rd_rdy, 0);
        cyc();
        wr_req = 1'b0; rd_req = 1'b1;
        #1;
        chk("haz_pending", rd_rdy, 0);
        chk("byte_awvalid", awvalid, 1);
        chk("byte_awsize", awsize, 0);
        chk("byte_wstrb", wstrb, 4'b1000);
        chk("byte_wdata", wdata, 32'hAABB_CCDD);
        cyc();
        rd_addr = 32'h0000_4000;
        #1;
        chk("haz_other_line", rd_rdy, 1);
        cyc();
        rd_req = 1'b0;
        #1;
        chk("conc_arvalid", arvalid, 1);
        chk("conc_araddr", araddr, 32'h0000_4000);
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        cyc();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h4444_0000;
        rd_addr = 32'h0000_3000; rd_req = 1'b1;
        #1;
        chk("conc_ret_valid", ret_valid, 1);
        chk("conc_ret_data", ret_data, 32'h4444_0000);
        chk("conc_bready", bready, 1);
        cyc();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("haz_resp", rd_rdy, 0);
        cyc();
        bvalid = 1'b1;
        #1;
        chk("haz_bvalid", rd_rdy, 0);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("haz_release", rd_rdy, 1);
        cyc();
        rd_req = 1'b0;
        #1;
        chk("haz_read_araddr", araddr, 32'h0000_3000);
        chk("haz_read_arvalid", arvalid, 1);
        drain_read();

        // Same-cycle write and read to the same line
        cyc();
        wr_req = 1'b1; wr_type = CACHE_LINE; wr_addr = 32'h0000_5000; wr_data = '1;
        rd_req = 1'b1; rd_type = CACHE_WORD; rd_addr = 32'h0000_5004;
        #1;
        chk("same_wr_rdy", wr_rdy, 1);
        chk("same_rd_rdy", rd_rdy, 0);
        cyc();
        wr_req = 1'b0;
        #1;
        chk("same_awvalid", awvalid, 1);
        chk("same_arvalid", arvalid, 0);
        chk("same_rd_stall", rd_rdy, 0);
        rd_req = 1'b0;
        drain_write();
        #1;
        chk("same_rd_free", rd_rdy, 1);

        // Same-cycle write and read to different lines
        cyc();
        wr_req = 1'b1; wr_type = CACHE_WORD; wr_addr = 32'h0000_5000; wr_wstrb = 4'hF;
        rd_req = 1'b1; rd_type = CACHE_WORD; rd_addr = 32'h0000_6000;
        #1;
        chk("diff_wr_rdy", wr_rdy, 1);
        chk("diff_rd_rdy", rd_rdy, 1);
        cyc();
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        chk("diff_arvalid", arvalid, 1);
        chk("diff_araddr", araddr, 32'h0000_6000);
        chk("diff_awvalid", awvalid, 1);
        chk("diff_awaddr", awaddr, 32'h0000_5000);
        drain_read();
        drain_write();

        // Reset during beat 3 of a line read
        cyc();
        rd_req = 1'b1; rd_type = CACHE_LINE; rd_addr = 32'h0000_7000;
        cyc();
        rd_req = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1; rlast = 1'b0; rdata = 32'h7000 + b;
            cyc();
        end
        rvalid = 1'b1;
        #1;
        chk("pre_rst_ret_valid", ret_valid, 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_ret_valid", ret_valid, 0);
        cyc();
        #1;
        chk("mid_rst_rready_hold", rready, 0);
        chk("mid_rst_ret_valid_hold", ret_valid, 0);
        aresetn = 1'b1; rvalid = 1'b0;
        #1;
        chk("post_rst_rd_rdy", rd_rdy, 1);
        chk("post_rst_arvalid", arvalid, 0);
        do_read(rd_tab[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
